// File: rtl/clock_countdown_pkg.sv
// -----------------------------------------------------------------------------
// clock_countdown_pkg
// Shared types and constants for the clock_countdown reconfigurable slot.
//   state_e             : countdown FSM states (IDLE, RUN, HOLD, DONE)
//   DEFAULT_TICK_CYCLES : clock cycles per decrement step at default build
//   CNT_W               : width of the LED-style count bus
//   is_busy()           : true for the states in which the countdown is live
// -----------------------------------------------------------------------------
package clock_countdown_pkg;

   localparam int unsigned DEFAULT_TICK_CYCLES = 32'd62500000;
   localparam int unsigned CNT_W               = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   // RUN and HOLD both represent a countdown in progress (HOLD is just paused).
   function automatic logic is_busy(input state_e s);
      return (s == RUN) || (s == HOLD);
   endfunction

endpackage : clock_countdown_pkg

// File: rtl/clock_countdown_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to one decrement tick every TICK_CYCLES
// enabled cycles. Disabled cycles leave the counter untouched.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   en   in  count enable for this cycle
//   clr  in  synchronous clear, overrides en; no tick while clearing
//   tick out one-cycle pulse on the enabled cycle where the count wraps
// -----------------------------------------------------------------------------
module tick_prescaler
   import clock_countdown_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   PW   = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 32'd1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;
   logic          at_last;

   // Next prescaler value and the tick pulse; clear wins over counting.
   always_comb begin
      cnt_d   = cnt_q;
      at_last = (cnt_q == LAST);
      tick    = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (at_last) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + PW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prescaler register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/clock_countdown.sv
// -----------------------------------------------------------------------------
// clock_countdown
// Loadable 4-bit countdown timer that shares the LED-style `out` bus with the
// free-running up-counter so both can occupy the same reconfigurable slot.
// A load captures load_val and starts counting down one step per
// TICK_CYCLES enabled cycles; reaching zero emits a one-cycle `done` pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   run enable; low freezes prescaler and count (HOLD)
//   load      in   one-cycle strobe, captures load_val, highest after rst
//   load_val  in   [CNT_W] countdown start value
//   out       out  [CNT_W] current count, registered
//   busy      out  high while RUN or HOLD, registered
//   done      out  one-cycle expiry pulse, registered
//
// Build option: define CLOCK_COUNTDOWN_AUTO_RELOAD_EN to make expiry reload
// the last loaded value and keep running (periodic countdown). Default build
// halts at zero in DONE.
// -----------------------------------------------------------------------------
module clock_countdown
   import clock_countdown_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] out,
   output logic             busy,
   output logic             done
);

`ifdef CLOCK_COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] out_q;
   logic [CNT_W-1:0] out_d;
   logic [CNT_W-1:0] reload_q;
   logic [CNT_W-1:0] reload_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             psc_en;
   logic             tick;

   // The prescaler only advances while a countdown is live; a load restarts
   // it from zero, which also discards any tick landing on the load cycle.
   assign psc_en = en && is_busy(state_q);

   tick_prescaler #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (psc_en),
      .clr  (load),
      .tick (tick)
   );

   // Next-state, count, reload and output logic; load beats tick handling.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      if (load) begin
         out_d    = load_val;
         reload_d = load_val;
         if (load_val != '0) begin
            state_d = RUN;
         end else begin
            state_d = DONE;
            done_d  = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            RUN, HOLD: begin
               if (!en) begin
                  state_d = HOLD;
               end else if (tick) begin
                  if (out_q > CNT_W'(1)) begin
                     out_d   = out_q - CNT_W'(1);
                     state_d = RUN;
                  end else begin
                     // Expiry: pulse done, then either restart or halt at 0.
                     done_d = 1'b1;
                     if (AUTO_RELOAD && (reload_q != '0)) begin
                        out_d   = reload_q;
                        state_d = RUN;
                     end else begin
                        out_d   = '0;
                        state_d = DONE;
                     end
                  end
               end else begin
                  state_d = RUN;
               end
            end
            DONE: begin
               out_d   = '0;
               state_d = DONE;
            end
            default: begin
               out_d   = '0;
               state_d = IDLE;
            end
         endcase
      end

      // busy is registered from the state being entered so it lines up with out.
      busy_d = is_busy(state_d);
   end

   // State and output registers with synchronous reset; reset never pulses done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         out_q    <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : clock_countdown

// File: doc/clock_countdown.md
# clock_countdown

Reconfigurable-partition counter that runs the other way from the free-running up-counter: it is loaded with a 4-bit value and decrements once per prescaler period until it reaches zero. At zero it emits a one-cycle `done` pulse. It drives the same 4-bit LED-style `out` bus, so either module can occupy the same DFX slot. A single synchronous clock domain is used, with no handshakes beyond level/pulse control.

## Interface
- `TICK_CYCLES`, default 62500000: clock cycles per decrement step; must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; low freezes prescaler and count.
- `load`  in  1  one-cycle strobe; captures `load_val` and starts countdown.
- `load_val`  in  4  start value for the countdown.
- `out`  out  4  current count (registered).
- `busy`  out  1  high in RUN or HOLD.
- `done`  out  1  one-cycle pulse when count expires.

## Operation
- **Reset values:** `out` = 0, `busy` = 0, `done` = 0, state IDLE, prescaler 0, reload register 0.
- **States:** IDLE, RUN, HOLD, DONE.
- **Priority, highest first:** `rst`, then `load`, then `en`/tick logic.
- **`load` in any state:**
  - `out` ← `load_val` and reload register ← `load_val`.
  - Prescaler is cleared.
  - Next state is RUN if `load_val` ≠ 0; otherwise DONE with `done` pulsed.
- **RUN:**
  - `en` = 1: prescaler increments.
  - Tick occurs when prescaler == TICK_CYCLES−1; the prescaler wraps to 0 on that cycle.
  - On tick with `out` > 1: `out` ← `out` − 1.
  - On tick with `out` == 1: `out` ← 0, `done` = 1 next cycle, state DONE.
  - `en` = 0: state HOLD.
- **HOLD:**
  - Prescaler and `out` are frozen at their current values (prescaler is not cleared).
  - `en` = 1 returns to RUN and counting resumes where it left off.
- **DONE:** `out` holds 0 and `busy` = 0 until the next `load`.
- **IDLE:** inert until `load`; `en` is ignored.
- **Arithmetic:**
  - 4-bit unsigned.
  - `out` never wraps below 0.
  - Prescaler width is ceil(log2(TICK_CYCLES)) bits.
- **`load` coinciding with a tick:** the load wins; the tick is discarded and the prescaler restarts at 0.
- **`rst` asserted mid-countdown:** all state returns to reset values on the next edge, and no `done` pulse is emitted.

## Timing
- `load` sampled at edge n: `out` = `load_val` and `busy` = 1 after edge n.
- **First decrement:** exactly TICK_CYCLES enabled cycles after the load edge.
- **Decrement spacing:** consecutive decrements are TICK_CYCLES enabled cycles apart.
- **Cycles with `en` = 0:** do not count toward the prescaler.
- `done` is high for exactly one cycle, coincident with the first cycle `out` = 0.
- **`load_val` = 0:** `done` is high in the cycle after the load edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`CLOCK_COUNTDOWN_AUTO_RELOAD_EN` defined:**
  - On expiry, `done` still pulses, `out` ← reload register, and the state stays RUN.
  - This gives a periodic countdown.
  - If the reload register is 0, behaviour is the same as undefined.
- **Undefined (default):** expiry enters DONE and halts at 0.

## Structure
- **Package `clock_countdown_pkg`:**
  - State enum (IDLE, RUN, HOLD, DONE).
  - `DEFAULT_TICK_CYCLES` = 62500000.
  - Count width constant `CNT_W` = 4.
- **Sub-module `tick_prescaler`:**
  - Parameter `TICK_CYCLES`; inputs `clk`, `rst`, `en`, `clr`; output `tick`.
  - `tick` is a one-cycle pulse; `clr` resets the counter synchronously.
- **Top level:** FSM, count register, reload register and `done` register.

## Test plan
All scenarios use TICK_CYCLES = 4.
- **Basic countdown:** `en` = 1; load 3.
  - `out` goes 3→2→1→0 at 4, 8 and 12 cycles after the load.
  - `done` is high only in the cycle `out` first reads 0; `busy` drops on that same cycle.
- **Pause:** load 2; hold `en` = 0 for 10 cycles after cycle 2, then restore `en` = 1.
  - First decrement occurs at cycle 14 (2 + 10 + 2); `busy` stays 1 throughout.
- **Load zero:** load 0.
  - `out` = 0, `done` pulses in the next cycle, `busy` = 0.
- **Reload vs tick:** load 5, then assert load with `load_val` = 9 on the cycle a tick would fire.
  - `out` = 9, no decrement occurs, and the next decrement is 4 cycles later.
- **Reset mid-countdown:** assert `rst` while `out` = 2.
  - All outputs are 0 after one edge, no `done` pulse, and subsequent `en` is ignored until a load.
- **Auto-reload (macro defined):** load 2.
  - `done` pulses every 8 cycles; `out` sequences 2,1,2,1,…
